// File: rtl/lsu_lsq_ctrl_pkg.sv
// lsu_lsq_ctrl_pkg: shared sizing and one-hot decode helper for the LSQ controller.
package lsu_lsq_ctrl_pkg;
    localparam int LSQ_DEPTH = 8;
    localparam int LSQ_PTR_W = 3;
    function automatic logic [LSQ_DEPTH-1:0] onehot_dec(input logic [LSQ_PTR_W-1:0] idx);
        return LSQ_DEPTH'(1) << idx;
    endfunction
endpackage

// File: rtl/lsu_lsq_ctrl_age_picker.sv
// lsu_lsq_age_picker: oldest-first select, scanning the eligibility vector from head.
module lsu_lsq_age_picker #(
    parameter int LSQ_DEPTH = lsu_lsq_ctrl_pkg::LSQ_DEPTH,
    parameter int LSQ_PTR_W = lsu_lsq_ctrl_pkg::LSQ_PTR_W
) (
    input  logic [LSQ_DEPTH-1:0] elig,
    input  logic [LSQ_PTR_W-1:0] head,
    output logic                 vld,
    output logic [LSQ_PTR_W-1:0] idx
);
    logic [2*LSQ_DEPTH-1:0] w_dbl;
    logic [LSQ_DEPTH-1:0]   w_rot;
    logic [LSQ_PTR_W-1:0]   w_off;
    // rotate so that bit 0 is the head entry, then take the lowest set bit
    always_comb begin
        w_dbl = {elig, elig} >> head;
        w_rot = w_dbl[LSQ_DEPTH-1:0];
        w_off = '0;
        for (int i = LSQ_DEPTH - 1; i >= 0; i--)
            if (w_rot[i]) w_off = LSQ_PTR_W'(i);
        vld = |elig;
        idx = head + w_off;
    end
endmodule

// File: rtl/lsu_lsq_ctrl.sv
// lsu_lsq_ctrl: LSQ head/tail/count bookkeeping and alloc/exec/replay/invld strobe generation.
module lsu_lsq_ctrl #(
    parameter int LSQ_DEPTH = lsu_lsq_ctrl_pkg::LSQ_DEPTH,
    parameter int LSQ_PTR_W = lsu_lsq_ctrl_pkg::LSQ_PTR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 enq_vld_i,
    output logic                 enq_rdy_o,
    output logic [LSQ_PTR_W-1:0] enq_idx_o,
    output logic [LSQ_DEPTH-1:0] alloc_o,
    input  logic [LSQ_DEPTH-1:0] ent_vld_i,
    input  logic [LSQ_DEPTH-1:0] ent_awake_i,
    input  logic [LSQ_DEPTH-1:0] ent_exec_i,
    input  logic [LSQ_DEPTH-1:0] ent_succ_i,
    input  logic [LSQ_DEPTH-1:0] ent_virt_i,
    input  logic [LSQ_DEPTH-1:0] ent_exc_i,
    output logic                 iss_vld_o,
    output logic [LSQ_PTR_W-1:0] iss_idx_o,
    input  logic                 iss_rdy_i,
    output logic [LSQ_DEPTH-1:0] exec_o,
    input  logic                 rpl_vld_i,
    input  logic [LSQ_PTR_W-1:0] rpl_idx_i,
    output logic [LSQ_DEPTH-1:0] replay_o,
    output logic                 cmt_vld_o,
    output logic [LSQ_PTR_W-1:0] cmt_idx_o,
    input  logic                 cmt_rdy_i,
    output logic [LSQ_DEPTH-1:0] invld_o,
    output logic [LSQ_PTR_W:0]   cnt_o,
    output logic                 empty_o,
    output logic                 full_o
);
    import lsu_lsq_ctrl_pkg::*;

    logic [LSQ_PTR_W-1:0] r_head, r_tail;
    logic [LSQ_PTR_W:0]   r_cnt;
    logic [LSQ_DEPTH-1:0] w_elig;
    logic                 w_clr, w_enq_hs, w_iss_hs, w_cmt_hs;

    assign w_elig = ent_vld_i & ent_awake_i & ~ent_exec_i & ~ent_succ_i & ~ent_virt_i & ~ent_exc_i;

    lsu_lsq_age_picker #(.LSQ_DEPTH(LSQ_DEPTH), .LSQ_PTR_W(LSQ_PTR_W)) u_picker (
        .elig (w_elig),
        .head (r_head),
        .vld  (iss_vld_o),
        .idx  (iss_idx_o)
    );

    // flush/reset suppress every handshake in the same cycle; replay is a raw pass-through
    always_comb begin
        w_clr     = rst | flush;
        empty_o   = r_cnt == '0;
        full_o    = r_cnt == (LSQ_PTR_W+1)'(LSQ_DEPTH);
        enq_rdy_o = !full_o;
        cmt_vld_o = !empty_o & ent_vld_i[r_head] & (ent_succ_i[r_head] | ent_exc_i[r_head]);
        w_enq_hs  = !w_clr & enq_vld_i & enq_rdy_o;
        w_iss_hs  = !w_clr & iss_vld_o & iss_rdy_i;
        w_cmt_hs  = !w_clr & cmt_vld_o & cmt_rdy_i;
        alloc_o   = w_enq_hs ? onehot_dec(r_tail) : '0;
        exec_o    = w_iss_hs ? onehot_dec(iss_idx_o) : '0;
        invld_o   = w_cmt_hs ? onehot_dec(r_head) : '0;
        replay_o  = rpl_vld_i ? onehot_dec(rpl_idx_i) : '0;
        enq_idx_o = r_tail;
        cmt_idx_o = r_head;
        cnt_o     = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            r_tail <= r_tail + LSQ_PTR_W'(w_enq_hs);
            r_head <= r_head + LSQ_PTR_W'(w_cmt_hs);
            r_cnt  <= r_cnt + (LSQ_PTR_W+1)'(w_enq_hs) - (LSQ_PTR_W+1)'(w_cmt_hs);
        end
    end
endmodule

// File: tb/tb_lsu_lsq_ctrl.sv
// tb_lsu_lsq_ctrl: directed self-checking bench for the LSQ controller.
module tb_lsu_lsq_ctrl;
    logic       clk = 0, rst, flush, enq_vld_i, iss_rdy_i, rpl_vld_i, cmt_rdy_i;
    logic [2:0] rpl_idx_i, enq_idx_o, iss_idx_o, cmt_idx_o;
    logic [7:0] ent_vld_i, ent_awake_i, ent_exec_i, ent_succ_i, ent_virt_i, ent_exc_i;
    logic [7:0] alloc_o, exec_o, replay_o, invld_o;
    logic       enq_rdy_o, iss_vld_o, cmt_vld_o, empty_o, full_o;
    logic [3:0] cnt_o;
    int         n_chk = 0, n_pass = 0;

    lsu_lsq_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_vld_i(enq_vld_i), .enq_rdy_o(enq_rdy_o), .enq_idx_o(enq_idx_o), .alloc_o(alloc_o),
        .ent_vld_i(ent_vld_i), .ent_awake_i(ent_awake_i), .ent_exec_i(ent_exec_i),
        .ent_succ_i(ent_succ_i), .ent_virt_i(ent_virt_i), .ent_exc_i(ent_exc_i),
        .iss_vld_o(iss_vld_o), .iss_idx_o(iss_idx_o), .iss_rdy_i(iss_rdy_i), .exec_o(exec_o),
        .rpl_vld_i(rpl_vld_i), .rpl_idx_i(rpl_idx_i), .replay_o(replay_o),
        .cmt_vld_o(cmt_vld_o), .cmt_idx_o(cmt_idx_o), .cmt_rdy_i(cmt_rdy_i), .invld_o(invld_o),
        .cnt_o(cnt_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clr_ent;
        ent_vld_i = 0; ent_awake_i = 0; ent_exec_i = 0;
        ent_succ_i = 0; ent_virt_i = 0; ent_exc_i = 0;
    endtask

    initial begin
        rst = 1; flush = 0; enq_vld_i = 0; iss_rdy_i = 0; rpl_vld_i = 0; rpl_idx_i = 0; cmt_rdy_i = 0;
        clr_ent();
        tick; tick;
        rst = 0;
        #1;
        chk("rst_cnt", cnt_o, 0);
        chk("rst_enq_rdy", enq_rdy_o, 1);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_strobes", {alloc_o, exec_o, replay_o, invld_o}, 0);
        chk("rst_vlds", {iss_vld_o, cmt_vld_o}, 0);
        chk("rst_idx", {enq_idx_o, iss_idx_o, cmt_idx_o}, 0);

        // eight back-to-back enqueues, tail wraps 7 -> 0
        enq_vld_i = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fill_alloc", alloc_o, 32'(1) << i);
            chk("fill_idx", enq_idx_o, i);
            tick;
        end
        #1;
        chk("full_flag", full_o, 1);
        chk("full_enq_rdy", enq_rdy_o, 0);
        chk("full_alloc", alloc_o, 0);
        chk("full_cnt", cnt_o, 8);
        chk("tail_wrap", enq_idx_o, 0);
        enq_vld_i = 0;

        // retire six to move head to 6
        ent_vld_i = 8'hFF; ent_succ_i = 8'hFF; cmt_rdy_i = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("ret_vld", cmt_vld_o, 1);
            chk("ret_invld", invld_o, 32'(1) << i);
            tick;
        end
        cmt_rdy_i = 0;
        #1;
        chk("ret_head", cmt_idx_o, 6);
        chk("ret_cnt", cnt_o, 2);

        clr_ent();
        enq_vld_i = 1;
        tick; tick;
        enq_vld_i = 0;

        // head 6, entries 6,7,0,1 valid, only 7 and 0 eligible
        ent_vld_i = 8'hC3; ent_awake_i = 8'hC3; ent_virt_i = 8'h40; ent_exc_i = 8'h02;
        #1;
        chk("pick_vld", iss_vld_o, 1);
        chk("pick_idx", iss_idx_o, 7);
        chk("pick_noexec", exec_o, 0);
        chk("pick_cmt", cmt_vld_o, 0);
        iss_rdy_i = 1; rpl_vld_i = 1; rpl_idx_i = 7;
        #1;
        chk("pick_exec", exec_o, 8'h80);
        chk("pick_replay", replay_o, 8'h80);
        ent_virt_i = 0;
        #1;
        chk("pick_head", iss_idx_o, 6);
        ent_awake_i = 8'h03;
        #1;
        chk("pick_wrap", iss_idx_o, 0);
        clr_ent();
        iss_rdy_i = 0; rpl_vld_i = 0;
        #1;
        chk("pick_none", iss_vld_o, 0);

        // drain to head 2, then put one entry there
        ent_vld_i = 8'hFF; ent_succ_i = 8'hFF; cmt_rdy_i = 1;
        repeat (4) tick;
        cmt_rdy_i = 0;
        #1;
        chk("drain_head", cmt_idx_o, 2);
        chk("drain_empty", empty_o, 1);
        chk("drain_cmt", cmt_vld_o, 0);
        clr_ent();
        enq_vld_i = 1;
        tick;
        enq_vld_i = 0;

        // retire head 2 with a concurrent enqueue at tail 3
        ent_vld_i = 8'h04; ent_succ_i = 8'h04; cmt_rdy_i = 1; enq_vld_i = 1;
        #1;
        chk("cc_cmt_vld", cmt_vld_o, 1);
        chk("cc_invld", invld_o, 8'h04);
        chk("cc_alloc", alloc_o, 8'h08);
        tick;
        cmt_rdy_i = 0; enq_vld_i = 0; clr_ent();
        #1;
        chk("cc_cnt", cnt_o, 1);
        chk("cc_head", cmt_idx_o, 3);
        chk("cc_tail", enq_idx_o, 4);

        enq_vld_i = 1;
        repeat (7) tick;
        enq_vld_i = 0;
        #1;
        chk("refill_full", full_o, 1);
        chk("refill_tail", enq_idx_o, 3);

        // full: retire plus enqueue offer must not allocate
        ent_vld_i = 8'hFF; ent_succ_i = 8'h08; cmt_rdy_i = 1; enq_vld_i = 1;
        #1;
        chk("fr_alloc", alloc_o, 0);
        chk("fr_enq_rdy", enq_rdy_o, 0);
        chk("fr_invld", invld_o, 8'h08);
        tick;
        cmt_rdy_i = 0; enq_vld_i = 0;
        #1;
        chk("fr_cnt", cnt_o, 7);
        chk("fr_full", full_o, 0);
        chk("fr_head", cmt_idx_o, 4);
        chk("fr_tail", enq_idx_o, 3);

        // down to 5 entries (head 6), then flush during an issue handshake
        ent_succ_i = 8'hFF; cmt_rdy_i = 1;
        tick; tick;
        cmt_rdy_i = 0;
        ent_vld_i = 8'hC7; ent_awake_i = 8'hC7; ent_succ_i = 0; iss_rdy_i = 1;
        #1;
        chk("fl_cnt5", cnt_o, 5);
        chk("fl_pick", iss_idx_o, 6);
        chk("fl_exec_pre", exec_o, 8'h40);
        flush = 1; enq_vld_i = 1;
        #1;
        chk("fl_exec", exec_o, 0);
        chk("fl_alloc", alloc_o, 0);
        tick;
        flush = 0; enq_vld_i = 0; iss_rdy_i = 0; clr_ent();
        #1;
        chk("fl_cnt", cnt_o, 0);
        chk("fl_head", cmt_idx_o, 0);
        chk("fl_tail", enq_idx_o, 0);
        chk("fl_iss", iss_vld_o, 0);
        chk("fl_empty", empty_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_lsq_ctrl.md
# lsu_lsq_ctrl

Allocation, issue-select and retire controller for the load/store queue. It owns the circular head/tail pointers and occupancy count for the array of per-entry LSQ state registers. It turns dispatch, cache-issue and commit handshakes into the one-hot `alloc`, `exec`, `replay` and `invld` strobes those entries consume. It sits between dispatch/ROB and the entry array, and picks the oldest ready entry for the D-cache port.

## Interface
Reset is `rst`, synchronous, active-high; clock is `clk`.

Parameters:
- `LSQ_DEPTH`, 8: number of entries; power of two, ≥ 2.
- `LSQ_PTR_W`, 3: log2(`LSQ_DEPTH`).

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous active-high reset.
- `flush` input 1: pipeline flush; same effect as `rst`.
- `enq_vld_i` input 1: dispatch offers an instruction.
- `enq_rdy_o` output 1: a free entry exists.
- `enq_idx_o` output `LSQ_PTR_W`: entry being allocated (current tail).
- `alloc_o` output `LSQ_DEPTH`: one-hot init strobe to entry `lsq_entry_vld_i`.
- `ent_vld_i` input `LSQ_DEPTH`: per-entry valid.
- `ent_awake_i` input `LSQ_DEPTH`: per-entry awake.
- `ent_exec_i` input `LSQ_DEPTH`: per-entry exec.
- `ent_succ_i` input `LSQ_DEPTH`: per-entry succ.
- `ent_virt_i` input `LSQ_DEPTH`: per-entry virt, i.e. tag not yet translated.
- `ent_exc_i` input `LSQ_DEPTH`: per-entry exception valid.
- `iss_vld_o` output 1: an issue candidate exists.
- `iss_idx_o` output `LSQ_PTR_W`: index of the candidate.
- `iss_rdy_i` input 1: D-cache accepts the candidate.
- `exec_o` output `LSQ_DEPTH`: one-hot exec strobe.
- `rpl_vld_i` input 1: D-cache requests a replay.
- `rpl_idx_i` input `LSQ_PTR_W`: entry to replay.
- `replay_o` output `LSQ_DEPTH`: one-hot replay strobe.
- `cmt_vld_o` output 1: head entry is ready to retire.
- `cmt_idx_o` output `LSQ_PTR_W`: head index.
- `cmt_rdy_i` input 1: ROB accepts the retire.
- `invld_o` output `LSQ_DEPTH`: one-hot dequeue strobe.
- `cnt_o` output `LSQ_PTR_W+1`: occupancy.
- `empty_o` output 1: queue is empty.
- `full_o` output 1: queue is full.

## Operation
- State:
  - head pointer and tail pointer, `LSQ_PTR_W` bits each, wrapping modulo `LSQ_DEPTH`;
  - `cnt`, `LSQ_PTR_W+1` bits.
- Reset and flush:
  - head, tail and cnt are cleared to 0;
  - a flush overrides every handshake in the same cycle.
- Reset values of outputs:
  - `enq_rdy_o` = 1, `empty_o` = 1, `full_o` = 0, `cnt_o` = 0;
  - all one-hot strobes, `iss_vld_o` and `cmt_vld_o` are 0;
  - all index outputs are 0.
- Enqueue:
  - `enq_rdy_o` = !full;
  - a handshake (`enq_vld_i & enq_rdy_o`) drives `alloc_o[tail]` = 1 and increments tail at the next edge.
- Issue eligibility: entry i is eligible when `vld & awake & !exec & !succ & !virt & !exc`.
- Issue select:
  - the selected entry is the first eligible entry scanning from head toward tail (oldest-first rotating priority);
  - `iss_vld_o` = any eligible;
  - a handshake drives `exec_o[iss_idx_o]` = 1.
- Replay: `replay_o[rpl_idx_i]` = `rpl_vld_i`. The pass-through is unconditional.
- Retire:
  - `cmt_vld_o` = !empty & `ent_vld_i[head]` & (`ent_succ_i[head]` | `ent_exc_i[head]`);
  - a handshake drives `invld_o[head]` = 1 and increments head.
- Count:
  - cnt_next = cnt + enq_hs − cmt_hs;
  - simultaneous enqueue and retire leaves cnt unchanged;
  - when full, a retire in the same cycle does not enable an enqueue, because `enq_rdy_o` is based only on registered cnt.
- Conflicts:
  - exec and replay on the same index in one cycle: both strobes assert, and the entry gives replay priority;
  - an issue handshake on the head while it is retiring is impossible, since succ excludes eligibility.

## Timing
- All selects and strobes are combinational from registered pointers and entry state, so a strobe is seen in the same cycle as its handshake.
- Entry state updates at the next edge.
- Pointer and cnt updates take effect one edge after the handshake.
- A newly allocated entry is eligible no earlier than 1 cycle after its alloc, once its awake bit is registered.
- Back-to-back enqueue at 1 per cycle sustains until full.
- Wrap-around: tail = `LSQ_DEPTH`−1 → 0 with no bubble.

## Structure
- The shared package holds `LSQ_DEPTH`, `LSQ_PTR_W` and a `onehot_dec` function.
- Sub-module `lsu_lsq_age_picker` performs the rotating oldest-first priority select. It takes an eligibility vector and head, and returns `vld` and `idx`.

## Test plan
- Reset → `cnt_o` = 0, `enq_rdy_o` = 1, all strobes 0.
- Eight enqueues (depth 8) → `alloc_o` = 0x01, 0x02 … 0x80 on successive cycles; `full_o` = 1 and `enq_rdy_o` = 0 after the 8th.
- Head = 6, entries 6, 7, 0, 1 valid, entries 0 and 7 eligible → `iss_idx_o` = 7; with `iss_rdy_i` = 1, `exec_o` = 0x80.
- Head 2 with succ = 1 and `cmt_rdy_i` = 1, plus a concurrent enqueue → `invld_o` = 0x04, `alloc_o` at the tail, cnt unchanged, head = 3.
- Full queue with a retire and `enq_vld_i` in the same cycle → no alloc; cnt = 7 next cycle.
- `flush` while 5 entries are valid and an issue handshake is active → next cycle head = tail = cnt = 0, `iss_vld_o` = 0.
